// File: rtl/iob_bus_arbiter2_if.sv
// IOb native port bundle shared by the arbiter's requester and memory sides.
//   valid/addr/wdata/wstrb : request, driven by the master side
//   ready                  : request accepted this cycle, driven by the slave side
//   rdata/rvalid           : read response, driven by the slave side
// wstrb all zero marks a read.
interface iob_bus_arbiter2_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata, rvalid);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata, rvalid);
endinterface

// File: rtl/iob_bus_arbiter2.sv
// Two-requester round-robin arbiter in front of one IOb memory port.
// Each read locks the grant until its rvalid returns; a watchdog aborts a
// read whose response never comes and raises a sticky timeout flag.
//   clk_i, arst_n_i (async, active-low), cke_i (state hold when low)
//   s0, s1    : requester ports (slave modport)
//   m         : shared memory port (master modport)
//   timeout_o : sticky, set when a read was aborted by the watchdog
module iob_bus_arbiter2 #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  iob_bus_arbiter2_if.slave     s0,
  iob_bus_arbiter2_if.slave     s1,
  iob_bus_arbiter2_if.master    m,
  output logic                  timeout_o
);

  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [TIMEOUT_W-1:0] wcnt_q, wcnt_d;
  logic                 timeout_d;

  logic                 sel, sel_valid, rsp, abort;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [DATA_W/8-1:0]  sel_wstrb;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_o;
    rsp       = 1'b0;
    abort     = 1'b0;

    // Sole valid requester wins; on a tie the one not served last wins.
    sel       = s0.valid ? (s1.valid & ~last_q) : s1.valid;
    sel_valid = s0.valid | s1.valid;
    sel_addr  = sel ? s1.addr  : s0.addr;
    sel_wdata = sel ? s1.wdata : s0.wdata;
    sel_wstrb = sel ? s1.wstrb : s0.wstrb;

    m.valid  = 1'b0;
    m.addr   = '0;
    m.wdata  = '0;
    m.wstrb  = '0;
    s0.ready = 1'b0;
    s1.ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          m.valid  = 1'b1;
          m.addr   = sel_addr;
          m.wdata  = sel_wdata;
          m.wstrb  = sel_wstrb;
          s0.ready = ~sel & m.ready;
          s1.ready = sel & m.ready;
          if (m.ready) begin
            last_d = sel;
            if (sel_wstrb == '0) begin
              owner_d = sel;
              wcnt_d  = '0;
              state_d = WAIT_RD;
            end
          end
        end
      end
      WAIT_RD: begin
        if (m.rvalid) begin
          rsp     = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q == '1) begin
          rsp       = 1'b1;
          abort     = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
    endcase

    // Responses only ever reach the owner; an aborted read returns zero data.
    s0.rvalid = rsp & ~owner_q;
    s1.rvalid = rsp & owner_q;
    s0.rdata  = (~owner_q & ~abort) ? m.rdata : '0;
    s1.rdata  = (owner_q & ~abort) ? m.rdata : '0;

    // Handshake and data outputs read as zero for as long as reset is held.
    if (!arst_n_i) begin
      m.valid   = 1'b0;
      s0.ready  = 1'b0;
      s1.ready  = 1'b0;
      s0.rvalid = 1'b0;
      s1.rvalid = 1'b0;
      s0.rdata  = '0;
      s1.rdata  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      wcnt_q    <= '0;
      timeout_o <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      timeout_o <= timeout_d;
    end
  end

endmodule

// File: tb/tb_iob_bus_arbiter2.sv
// Directed bench for iob_bus_arbiter2: a table of single-cycle arbitration
// vectors followed by hand-written multi-cycle read, backpressure, watchdog
// and reset sequences.
module tb_iob_bus_arbiter2;

  logic clk = 1'b0;
  logic rst_n;
  logic cke;
  logic timeout;

  int checks   = 0;
  int failures = 0;

  iob_bus_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  iob_bus_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  iob_bus_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  iob_bus_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(3)) dut (
    .clk_i     (clk),
    .arst_n_i  (rst_n),
    .cke_i     (cke),
    .s0        (s0_if),
    .s1        (s1_if),
    .m         (m_if),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] WMASK = 32'h5A5A_0000;

  typedef struct {
    logic        cke;
    logic        v0;
    logic        v1;
    logic        rdy;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        exp_mv;
    logic [31:0] exp_addr;
    logic        exp_r0;
    logic        exp_r1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.valid = 1'b0; s0_if.addr = '0; s0_if.wdata = '0; s0_if.wstrb = '0;
    s1_if.valid = 1'b0; s1_if.addr = '0; s1_if.wdata = '0; s1_if.wstrb = '0;
    m_if.ready = 1'b1; m_if.rdata = '0; m_if.rvalid = 1'b0;
    cke = 1'b1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    next_cyc();
  endtask

  initial begin
    int cnt0, cnt1, exp_g;

    //            cke v0 v1 rdy a0     a1     mv addr   r0 r1
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h00, 1'b1, 32'h10, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 32'h20, 1'b1, 32'h20, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h34, 1'b1, 32'h30, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h38, 32'h3C, 1'b1, 32'h3C, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h44, 1'b1, 32'h40, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h44, 1'b1, 32'h40, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h50, 32'h54, 1'b1, 32'h54, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h60, 32'h64, 1'b1, 32'h60, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h60, 32'h64, 1'b1, 32'h60, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h68, 32'h6C, 1'b1, 32'h68, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 32'h70, 1'b1, 32'h70, 1'b0, 1'b1};

    // Reset state: a pending request and read data must not leak through.
    rst_n = 1'b0;
    clear_inputs();
    s0_if.valid = 1'b1; s0_if.addr = 32'h99; s0_if.wstrb = 4'hF;
    m_if.rdata = 32'hFFFF_FFFF;
    #2;
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_s0_ready", s0_if.ready, 0);
    chk("rst_s0_rdata", s0_if.rdata, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    next_cyc();

    // Single-cycle arbitration table (all writes, state stays IDLE).
    for (int i = 0; i < 12; i++) begin
      cke = vecs[i].cke;
      m_if.ready = vecs[i].rdy;
      s0_if.valid = vecs[i].v0; s0_if.addr = vecs[i].a0;
      s0_if.wdata = vecs[i].a0 ^ WMASK; s0_if.wstrb = 4'hF;
      s1_if.valid = vecs[i].v1; s1_if.addr = vecs[i].a1;
      s1_if.wdata = vecs[i].a1 ^ WMASK; s1_if.wstrb = 4'hF;
      @(negedge clk);
      chk($sformatf("vec%0d_m_valid", i), m_if.valid, vecs[i].exp_mv);
      chk($sformatf("vec%0d_m_addr", i), m_if.addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_m_wdata", i), m_if.wdata,
          vecs[i].exp_mv ? (vecs[i].exp_addr ^ WMASK) : 32'h0);
      chk($sformatf("vec%0d_m_wstrb", i), m_if.wstrb, vecs[i].exp_mv ? 32'hF : 32'h0);
      chk($sformatf("vec%0d_s0_ready", i), s0_if.ready, vecs[i].exp_r0);
      chk($sformatf("vec%0d_s1_ready", i), s1_if.ready, vecs[i].exp_r1);
      next_cyc();
    end
    clear_inputs();

    // Back-to-back writes, four per requester: grants alternate from 0.
    cnt0 = 4; cnt1 = 4;
    for (int c = 0; c < 8; c++) begin
      exp_g = c % 2;
      s0_if.valid = (cnt0 > 0); s0_if.addr = 32'h100 + c; s0_if.wstrb = 4'hF;
      s1_if.valid = (cnt1 > 0); s1_if.addr = 32'h200 + c; s1_if.wstrb = 4'hF;
      @(negedge clk);
      chk($sformatf("b2b%0d_s0_ready", c), s0_if.ready, (exp_g == 0) ? 1 : 0);
      chk($sformatf("b2b%0d_s1_ready", c), s1_if.ready, (exp_g == 1) ? 1 : 0);
      if (exp_g == 0) cnt0--; else cnt1--;
      next_cyc();
    end
    clear_inputs();

    // Contention after reset: both read, rvalid two cycles after accept.
    reset_pulse();
    s0_if.valid = 1'b1; s0_if.addr = 32'hA0;
    s1_if.valid = 1'b1; s1_if.addr = 32'hB0;
    @(negedge clk);
    chk("cont_s0_ready", s0_if.ready, 1);
    chk("cont_s1_ready_a", s1_if.ready, 0);
    next_cyc();
    s0_if.valid = 1'b0;
    @(negedge clk);
    chk("cont_wait_m_valid", m_if.valid, 0);
    chk("cont_wait_s1_ready", s1_if.ready, 0);
    next_cyc();
    m_if.rvalid = 1'b1; m_if.rdata = 32'h1234;
    @(negedge clk);
    chk("cont_s0_rvalid", s0_if.rvalid, 1);
    chk("cont_s0_rdata", s0_if.rdata, 32'h1234);
    chk("cont_s1_rvalid_a", s1_if.rvalid, 0);
    chk("cont_s1_rdata_a", s1_if.rdata, 0);
    next_cyc();
    m_if.rvalid = 1'b0;
    @(negedge clk);
    chk("cont_s1_ready_b", s1_if.ready, 1);
    chk("cont_m_addr_b", m_if.addr, 32'hB0);
    next_cyc();
    s1_if.valid = 1'b0;
    next_cyc();
    m_if.rvalid = 1'b1; m_if.rdata = 32'hBEEF;
    @(negedge clk);
    chk("cont_s1_rvalid", s1_if.rvalid, 1);
    chk("cont_s1_rdata", s1_if.rdata, 32'hBEEF);
    chk("cont_s0_rvalid_b", s0_if.rvalid, 0);
    chk("cont_s0_rdata_b", s0_if.rdata, 0);
    next_cyc();
    clear_inputs();

    // Backpressure: s1 read held for three cycles, accepted on the fourth.
    s1_if.valid = 1'b1; s1_if.addr = 32'h80;
    m_if.ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_s1_ready", c), s1_if.ready, 0);
      chk($sformatf("bp%0d_m_addr", c), m_if.addr, 32'h80);
      chk($sformatf("bp%0d_m_valid", c), m_if.valid, 1);
      next_cyc();
    end
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_s1_ready", s1_if.ready, 1);
    next_cyc();
    s1_if.valid = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hCAFE;
    @(negedge clk);
    chk("bp_s1_rvalid", s1_if.rvalid, 1);
    chk("bp_s1_rdata", s1_if.rdata, 32'hCAFE);
    next_cyc();
    clear_inputs();

    // Watchdog: read with no response aborts when the wait counter hits 7.
    s0_if.valid = 1'b1; s0_if.addr = 32'hC0;
    @(negedge clk);
    chk("wd_s0_ready", s0_if.ready, 1);
    next_cyc();
    s0_if.valid = 1'b0;
    m_if.rdata = 32'hDEAD;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("wd_wait%0d_rvalid", c), s0_if.rvalid, 0);
      next_cyc();
    end
    @(negedge clk);
    chk("wd_s0_rvalid", s0_if.rvalid, 1);
    chk("wd_s0_rdata", s0_if.rdata, 0);
    chk("wd_s1_rvalid", s1_if.rvalid, 0);
    chk("wd_timeout_pre", timeout, 0);
    next_cyc();
    s1_if.valid = 1'b1; s1_if.addr = 32'hD0; s1_if.wstrb = 4'hF;
    @(negedge clk);
    chk("wd_timeout", timeout, 1);
    chk("wd_s1_wr_ready", s1_if.ready, 1);
    next_cyc();
    clear_inputs();
    @(negedge clk);
    chk("wd_timeout_sticky", timeout, 1);
    next_cyc();

    // Async reset while a read is outstanding.
    s0_if.valid = 1'b1; s0_if.addr = 32'hE0;
    @(negedge clk);
    chk("ar_s0_ready", s0_if.ready, 1);
    next_cyc();
    s0_if.valid = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h77;
    #1;
    chk("ar_pre_rvalid", s0_if.rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_rvalid", s0_if.rvalid, 0);
    chk("ar_rdata", s0_if.rdata, 0);
    chk("ar_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_stray_s0_rvalid", s0_if.rvalid, 0);
    chk("ar_stray_s1_rvalid", s1_if.rvalid, 0);
    next_cyc();
    chk("ar_stray2_s0_rvalid", s0_if.rvalid, 0);
    m_if.rvalid = 1'b0;
    s0_if.valid = 1'b1; s0_if.addr = 32'hF0;
    s1_if.valid = 1'b1; s1_if.addr = 32'hF4;
    @(negedge clk);
    chk("ar_tie_s0_ready", s0_if.ready, 1);
    chk("ar_tie_s1_ready", s1_if.ready, 0);
    chk("ar_tie_m_addr", m_if.addr, 32'hF0);
    next_cyc();
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
